// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//   8N1 UART transmitter fed from the AHB UART register block. Bytes written
//   with tx_en are held in a buffer and shifted out LSB first, one bit every
//   BAUD_DIV HCLK cycles, with back-to-back frames when the buffer is not empty.
//
//   Build option: define UART_TX_FIFO_EN to buffer bytes in a 2^FIFO_AW entry
//   FIFO; otherwise a single holding register (depth 1) is used.
//
// Parameters
//   BAUD_DIV  HCLK cycles per serial bit (2..65535)
//   FIFO_AW   FIFO address width, depth 2^FIFO_AW (UART_TX_FIFO_EN only)
//
// Ports
//   HCLK     in   system clock, rising edge
//   HRESETn  in   asynchronous active-low reset
//   tx_en    in   one-cycle write strobe
//   tx_data  in   byte to send, sampled when tx_en=1
//   txd      out  serial line, registered, idle high
//   state    out  buffer full (writes not accepted), registered
//   tx_busy  out  frame in progress or buffer non-empty
//   tx_ovf   out  one-cycle pulse after a dropped write
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int unsigned BAUD_DIV = 434,
    parameter int unsigned FIFO_AW  = 4
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       state,
    output logic       tx_busy,
    output logic       tx_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } fsm_t;

    fsm_t        fsm_q;
    fsm_t        fsm_d;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_end;
    logic        buf_empty;
    logic        buf_full;
    logic [7:0]  buf_head;
    logic        pop;
    logic        push;
    logic        txd_d;

    assign bit_end = (baud_cnt == 16'(BAUD_DIV - 1));

    // Pop on entry to START, from IDLE or straight out of the stop bit, so
    // consecutive frames have no idle gap between them.
    assign pop  = !buf_empty &&
                  ((fsm_q == IDLE) || ((fsm_q == STOP) && bit_end));
    // A write at full is still accepted when the same edge frees a slot.
    assign push = tx_en && (!buf_full || pop);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [FIFO_AW:0] wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_d;
    logic             full_q;

    assign wr_ptr_d = push ? wr_ptr + (FIFO_AW + 1)'(1) : wr_ptr;
    assign rd_ptr_d = pop  ? rd_ptr + (FIFO_AW + 1)'(1) : rd_ptr;

    // Full flag is registered from the next pointer values: same index,
    // opposite wrap bit.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full_q <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            full_q <= (wr_ptr_d[FIFO_AW] != rd_ptr_d[FIFO_AW]) &&
                      (wr_ptr_d[FIFO_AW-1:0] == rd_ptr_d[FIFO_AW-1:0]);
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= tx_data;
        end
    end

    assign buf_empty = (wr_ptr == rd_ptr);
    assign buf_full  = full_q;
    assign buf_head  = mem[rd_ptr[FIFO_AW-1:0]];
`else
    logic [7:0] hold_q;
    logic       valid_q;
    // FIFO_AW only sizes the FIFO build.
    logic       unused_fifo_aw;

    assign unused_fifo_aw = (FIFO_AW != 0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                hold_q  <= tx_data;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign buf_empty = !valid_q;
    assign buf_full  = valid_q;
    assign buf_head  = hold_q;
`endif

    // FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next state
    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:  if (!buf_empty) fsm_d = START;
            START: if (bit_end) fsm_d = DATA;
            DATA:  if (bit_end && (bit_idx == 3'd7)) fsm_d = STOP;
            STOP:  if (bit_end) fsm_d = buf_empty ? IDLE : START;
            default: fsm_d = IDLE;
        endcase
    end

    // Baud counter, bit index and shift register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else if (pop) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= buf_head;
        end else if (fsm_q != IDLE) begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 16'd1;
            if ((fsm_q == DATA) && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
                shreg   <= {1'b0, shreg[7:1]};
            end
        end
    end

    // FSM outputs; txd is registered, so the line trails the FSM by one cycle.
    always_comb begin
        txd_d = 1'b1;
        unique case (fsm_q)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg[0];
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            txd    <= 1'b1;
            tx_ovf <= 1'b0;
        end else begin
            txd    <= txd_d;
            tx_ovf <= tx_en && !push;
        end
    end

    assign state   = buf_full;
    assign tx_busy = (fsm_q != IDLE) || !buf_empty;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    localparam int BAUD = 4;

`ifdef UART_TX_FIFO_EN
    localparam logic ONE_FULL = 1'b0;
`else
    localparam logic ONE_FULL = 1'b1;
`endif

    logic       HCLK;
    logic       HRESETn;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       txd;
    logic       state;
    logic       tx_busy;
    logic       tx_ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames = 0;
    int ovf_cnt = 0;
    int last_start = 0;
    int prev_start = 0;
    logic in_frame = 1'b0;
    logic [7:0] sb [$];

    uart_tx_serializer #(.BAUD_DIV(BAUD), .FIFO_AW(4)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .tx_en   (tx_en),
        .tx_data (tx_data),
        .txd     (txd),
        .state   (state),
        .tx_busy (tx_busy),
        .tx_ovf  (tx_ovf)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc++;
    always @(negedge HCLK) if (tx_ovf === 1'b1) ovf_cnt++;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue a write; the byte goes on the scoreboard only if it should be sent.
    task automatic wr(input logic [7:0] b, input logic accept);
        @(negedge HCLK);
        tx_en   = 1'b1;
        tx_data = b;
        if (accept) sb.push_back(b);
    endtask

    task automatic wr_off();
        @(negedge HCLK);
        tx_en = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge HCLK);
            if (tx_busy === 1'b0 && !in_frame) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 40'(ok), 40'(1));
        repeat (2) @(negedge HCLK);
    endtask

    // Line monitor: captures 40 samples from a start bit and compares them
    // with the frame built from the oldest expected byte.
    always begin : monitor
        logic [39:0] obs;
        logic [39:0] exp;
        logic [9:0]  fbits;
        logic        aborted;
        int          t0;
        @(negedge HCLK);
        if (HRESETn === 1'b1 && txd === 1'b0) begin
            in_frame = 1'b1;
            aborted  = 1'b0;
            t0       = cyc;
            obs      = '0;
            obs[0]   = txd;
            for (int i = 1; i < 40; i++) begin
                @(negedge HCLK);
                if (HRESETn !== 1'b1) aborted = 1'b1;
                obs[i] = txd;
            end
            if (!aborted) begin
                if (sb.size() > 0) begin
                    fbits = {1'b1, sb.pop_front(), 1'b0};
                    for (int i = 0; i < 40; i++) exp[i] = fbits[i / BAUD];
                end else begin
                    exp = '1;
                end
                check("frame", obs, exp);
                prev_start = last_start;
                last_start = t0;
                frames++;
            end
            in_frame = 1'b0;
        end
    end

    initial begin : timeout
        #300000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int f0;
        int o0;
        int lows;
        logic seen;

        HRESETn = 1'b0;
        tx_en   = 1'b0;
        tx_data = 8'h00;
        #12;
        check("rst_txd", 40'(txd), 40'(1));
        check("rst_state", 40'(state), 40'(0));
        check("rst_busy", 40'(tx_busy), 40'(0));
        check("rst_ovf", 40'(tx_ovf), 40'(0));
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // Single frame 0xA5 and write-to-start latency
        f0 = frames; o0 = ovf_cnt;
        wr(8'hA5, 1'b1);
        wr_off();
        check("a5_state_after_wr", 40'(state), 40'(ONE_FULL));
        check("a5_busy_after_wr", 40'(tx_busy), 40'(1));
        check("a5_txd_write_edge", 40'(txd), 40'(1));
        @(negedge HCLK);
        check("a5_txd_pop_edge", 40'(txd), 40'(1));
        check("a5_state_after_pop", 40'(state), 40'(0));
        @(negedge HCLK);
        check("a5_txd_start", 40'(txd), 40'(0));
        wait_idle(100, "a5_idle");
        check("a5_frames", 40'(frames - f0), 40'(1));
        check("a5_sb_empty", 40'(sb.size()), 40'(0));
        check("a5_txd_idle", 40'(txd), 40'(1));
        check("a5_no_ovf", 40'(ovf_cnt - o0), 40'(0));

        // Back-to-back 0x00, 0xFF
        f0 = frames; o0 = ovf_cnt;
        wr(8'h00, 1'b1);
        wr(8'hFF, 1'b1);
        wr_off();
        wait_idle(200, "b2b_idle");
        check("b2b_frames", 40'(frames - f0), 40'(2));
        check("b2b_gap", 40'(last_start - prev_start), 40'(40));
        check("b2b_no_ovf", 40'(ovf_cnt - o0), 40'(0));

`ifdef UART_TX_FIFO_EN
        // 18 writes into an idle 16-deep FIFO, then a push on the pop edge
        f0 = frames; o0 = ovf_cnt;
        for (int i = 0; i < 18; i++) begin
            wr(8'(i * 29 + 7), (i < 17) ? 1'b1 : 1'b0);
            if (i == 17) begin
                check("fifo_full_before_drop", 40'(state), 40'(1));
                check("fifo_no_ovf_yet", 40'(tx_ovf), 40'(0));
            end
        end
        wr_off();
        check("fifo_ovf_pulse", 40'(tx_ovf), 40'(1));
        check("fifo_state_full", 40'(state), 40'(1));
        @(negedge HCLK);
        check("fifo_ovf_one_cycle", 40'(tx_ovf), 40'(0));
        repeat (21) @(negedge HCLK);
        check("fifo_full_at_pop", 40'(state), 40'(1));
        wr(8'hC3, 1'b1);
        wr_off();
        check("fifo_pop_edge_no_ovf", 40'(tx_ovf), 40'(0));
        check("fifo_pop_edge_state", 40'(state), 40'(1));
        wait_idle(1000, "fifo_idle");
        check("fifo_frames", 40'(frames - f0), 40'(18));
        check("fifo_ovf_count", 40'(ovf_cnt - o0), 40'(1));
`else
        // Holding register: drop while held, accept on the pop edge
        f0 = frames; o0 = ovf_cnt;
        wr(8'h3C, 1'b1);
        wr_off();
        wr(8'h11, 1'b1);
        wr(8'h22, 1'b0);
        wr_off();
        check("hold_ovf_pulse", 40'(tx_ovf), 40'(1));
        check("hold_state_full", 40'(state), 40'(1));
        @(negedge HCLK);
        check("hold_ovf_one_cycle", 40'(tx_ovf), 40'(0));
        repeat (35) @(negedge HCLK);
        check("hold_full_at_pop", 40'(state), 40'(1));
        wr(8'h33, 1'b1);
        wr_off();
        check("hold_pop_edge_no_ovf", 40'(tx_ovf), 40'(0));
        check("hold_pop_edge_state", 40'(state), 40'(1));
        @(negedge HCLK);
        check("hold_pop_edge_no_ovf2", 40'(tx_ovf), 40'(0));
        wait_idle(250, "hold_idle");
        check("hold_frames", 40'(frames - f0), 40'(3));
        check("hold_ovf_count", 40'(ovf_cnt - o0), 40'(1));
`endif

        // Reset during DATA bit 3
        f0 = frames;
        wr(8'h00, 1'b1);
        wr_off();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            if (txd === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check("rstmid_start_seen", 40'(seen), 40'(1));
        repeat (17) @(negedge HCLK);
        check("rstmid_bit3_low", 40'(txd), 40'(0));
        #2;
        HRESETn = 1'b0;
        #1;
        check("rstmid_txd", 40'(txd), 40'(1));
        check("rstmid_state", 40'(state), 40'(0));
        check("rstmid_busy", 40'(tx_busy), 40'(0));
        check("rstmid_ovf", 40'(tx_ovf), 40'(0));
        sb.delete();
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge HCLK);
            tx_data = 8'($urandom);
            if (txd !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("rstmid_quiet", 40'(lows), 40'(0));
        check("rstmid_no_frame", 40'(frames - f0), 40'(0));
        wr(8'h5A, 1'b1);
        wr_off();
        wait_idle(100, "rstmid_idle");
        check("rstmid_new_frame", 40'(frames - f0), 40'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
